// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract controller: one shared full-adder cell walks the
// operands LSB first, one bit per clock, then reports result and ALU flags.
`timescale 1ps/1ps

module serial_add_sequencer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic cell_sum;
  logic cell_carry;
  logic accept;

  adder u_cell (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .Cin  (carry_q),
    .out  (cell_sum),
    .Cout (cell_carry)
  );

  assign accept = start && (state_q != S_RUN);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;

    if (state_q == S_RUN) begin
      opa_d    = opa_q >> 1;
      opb_d    = opb_q >> 1;
      result_d = {cell_sum, result_q[WIDTH-1:1]};
      carry_d  = cell_carry;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CNT_PENULT) begin
        cmsb_d = cell_carry;
      end
      if (cnt_q == CNT_LAST) begin
        // Flags are captured on the same edge the final sum bit lands.
        state_d = S_DONE;
        cout_d  = cell_carry;
        ovf_d   = cmsb_q ^ cell_carry;
        zero_d  = ~|result_d;
        neg_d   = cell_sum;
      end
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
      state_d  = S_RUN;
      cnt_d    = '0;
      opa_d    = a;
      opb_d    = sub ? ~b : b;
      carry_d  = sub;
      cmsb_d   = 1'b0;
      result_d = '0;
      cout_d   = 1'b0;
      ovf_d    = 1'b0;
      zero_d   = 1'b0;
      neg_d    = 1'b0;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign ready    = (state_q != S_RUN);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule

// Gate-level 1-bit full adder shared across all bit positions.
module adder (
  input  logic a,
  input  logic b,
  input  logic Cin,
  output logic out,
  output logic Cout
);

  logic axb;
  logic gen;
  logic prop;

  xor g_x0 (axb, a, b);
  xor g_x1 (out, axb, Cin);
  and g_a0 (gen, a, b);
  and g_a1 (prop, axb, Cin);
  or  g_o0 (Cout, gen, prop);

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and random checks of the bit-serial add/sub sequencer at WIDTH=8.
`timescale 1ps/1ps

module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         ready, busy, done;
  logic [W-1:0] result;
  logic         cout, overflow, zero, negative;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  always #500 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after the accepting edge; done must appear in cycle 9.
  task automatic wait_done(input string tag, input int lat0);
    int lat;
    bit seen;
    lat  = lat0;
    seen = 1'b0;
    while (lat < 30 && !seen) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
    end
    check({tag, ":done_seen"}, 64'(seen), 64'd1);
    check({tag, ":latency"}, 64'(lat), 64'd9);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ta,
                              input logic [W-1:0] tb, input logic ts);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         exp_ovf;
    s = ts ? ({1'b0, ta} + {1'b0, ~tb} + 9'd1) : ({1'b0, ta} + {1'b0, tb});
    r = s[W-1:0];
    exp_ovf = ts ? ((ta[W-1] != tb[W-1]) && (r[W-1] != ta[W-1]))
                 : ((ta[W-1] == tb[W-1]) && (r[W-1] != ta[W-1]));
    check({tag, ":result"},   64'(result),   64'(r));
    check({tag, ":cout"},     64'(cout),     64'(s[W]));
    check({tag, ":overflow"}, 64'(overflow), 64'(exp_ovf));
    check({tag, ":zero"},     64'(zero),     64'(r == '0));
    check({tag, ":negative"}, 64'(negative), 64'(r[W-1]));
    check({tag, ":ready"},    64'(ready),    64'd1);
    check({tag, ":busy"},     64'(busy),     64'd0);
  endtask

  task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic ts);
    start_op(ta, tb, ts);
    wait_done(tag, 0);
    check_result(tag, ta, tb, ts);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen_done;

    #100 reset = 1'b1;
    #300;
    check("rst:result", 64'(result), 64'h0);
    check("rst:flags", 64'({cout, overflow, zero, negative}), 64'h0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:ready", 64'(ready), 64'd1);
    @(negedge clk) reset = 1'b0;

    // 1: reset in the middle of an operation discards it without a done pulse
    start_op(8'h0F, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1:busy_mid", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("t1:rst_result", 64'(result), 64'h0);
    check("t1:rst_flags", 64'({cout, overflow, zero, negative}), 64'h0);
    check("t1:rst_ready", 64'(ready), 64'd1);
    check("t1:rst_busy", 64'(busy), 64'd0);
    check("t1:rst_done", 64'(done), 64'd0);
    @(negedge clk) reset = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("t1:no_done_after_reset", 64'(seen_done), 64'd0);
    op("t1b", 8'h0F, 8'h01, 1'b0);
    check("t1b:result_const", 64'(result), 64'h10);

    // 2: carry out and zero result, done is a single-cycle pulse
    op("t2", 8'hFF, 8'h01, 1'b0);
    check("t2:zero_const", 64'(zero), 64'd1);
    @(negedge clk);
    check("t2:done_pulse", 64'(done), 64'd0);
    check("t2:result_held", 64'(result), 64'h00);
    check("t2:cout_held", 64'(cout), 64'd1);

    // 3: signed overflow on add and on subtract
    op("t3a", 8'h7F, 8'h01, 1'b0);
    check("t3a:ovf_const", 64'(overflow), 64'd1);
    op("t3b", 8'h80, 8'h01, 1'b1);
    check("t3b:result_const", 64'(result), 64'h7F);

    // 4: subtract with borrow
    op("t4", 8'h03, 8'h05, 1'b1);
    check("t4:result_const", 64'(result), 64'hFE);

    // 5: start ignored while busy; start during DONE runs back to back
    start_op(8'h40, 8'h05, 1'b0);
    @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    check("t5:ready_busy", 64'(ready), 64'd0);
    check("t5:busy_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t5a", 1);
    check_result("t5a", 8'h40, 8'h05, 1'b0);
    a = 8'h11; b = 8'h22; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t5b:busy_next", 64'(busy), 64'd1);
    check("t5b:done_not_double", 64'(done), 64'd0);
    wait_done("t5b", 1);
    check_result("t5b", 8'h11, 8'h22, 1'b0);
    check("t5b:result_const", 64'(result), 64'h33);

    // 6: random regression against the reference model
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      op("rnd", ra, rb, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
